// File: rtl/add_nnbit_serial_ctrl.sv
// ---------------------------------------------------------------------------
// add_nnbit_serial_ctrl
//   Bit-serial adder: a single full-adder cell is reused LSB-first, one bit
//   per clock, to form {o_cry, o_res} = i_num_a + i_num_b + i_cry.
//   Operands arrive through a valid/ready handshake. The result is handed to
//   the consumer through a second valid/ready handshake. Each operation takes
//   DATA_WIDTH cycles in RUN, plus one IDLE cycle and one DONE cycle.
//
// Ports
//   i_clk    : clock, all state updates on the rising edge
//   i_rst    : synchronous active-high reset
//   i_vld    : operand request valid
//   o_rdy    : operands can be accepted (IDLE only)
//   i_num_a  : operand A, sampled only at accept
//   i_num_b  : operand B, sampled only at accept
//   i_cry    : carry-in, sampled only at accept
//   o_vld    : result valid (DONE only)
//   i_rdy    : consumer takes the result
//   o_res    : sum; shows the partial shift register while in RUN
//   o_cry    : carry-out; shows the running carry while in RUN
//   o_busy   : high in RUN and DONE
// ---------------------------------------------------------------------------
module add_nnbit_serial_ctrl #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_cry,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cry,
    output logic                  o_busy
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] a_q,     a_d;
    logic [DATA_WIDTH-1:0] b_q,     b_d;
    logic [DATA_WIDTH-1:0] res_q,   res_d;
    logic                  cry_q,   cry_d;

    // The shared full-adder cell always looks at the current LSBs and carry.
    logic sum_bit;
    logic cry_bit;

    assign sum_bit = a_q[0] ^ b_q[0] ^ cry_q;
    assign cry_bit = (a_q[0] & b_q[0]) | (a_q[0] & cry_q) | (b_q[0] & cry_q);

    // State register and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cry_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cry_q   <= cry_d;
        end
    end

    // Next-state, datapath and handshake outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cry_d   = cry_q;
        o_rdy   = 1'b0;
        o_vld   = 1'b0;
        o_busy  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_rdy = 1'b1;
                if (i_vld) begin
                    a_d     = i_num_a;
                    b_d     = i_num_b;
                    cry_d   = i_cry;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                o_busy = 1'b1;
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                // New sum bit enters at the MSB; after DATA_WIDTH shifts the
                // first (LSB) sum bit has walked down to bit 0.
                res_d  = {sum_bit, res_q[DATA_WIDTH-1:1]};
                cry_d  = cry_bit;
                if (cnt_q == CNT_LAST) begin
                    // Return the counter to 0 rather than incrementing, so it
                    // never exceeds DATA_WIDTH-1 for non-power-of-two widths.
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                o_busy = 1'b1;
                o_vld  = 1'b1;
                if (i_rdy) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_res = res_q;
    assign o_cry = cry_q;

endmodule

// File: tb/tb_add_nnbit_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_add_nnbit_serial_ctrl
//   Directed checks of the bit-serial adder at DATA_WIDTH=4, plus random
//   vectors against a reference sum at DATA_WIDTH=4 and DATA_WIDTH=8.
// ---------------------------------------------------------------------------
module tb_add_nnbit_serial_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DATA_WIDTH = 4 instance
    logic       vld_in, rdy_out, cry_in, vld_out, rdy_in, cry_out, busy_out;
    logic [3:0] num_a, num_b, res_out;

    // DATA_WIDTH = 8 instance
    logic       vld_in8, rdy_out8, cry_in8, vld_out8, rdy_in8, cry_out8, busy_out8;
    logic [7:0] num_a8, num_b8, res_out8;

    add_nnbit_serial_ctrl #(.DATA_WIDTH(4)) dut4 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_vld   (vld_in),
        .o_rdy   (rdy_out),
        .i_num_a (num_a),
        .i_num_b (num_b),
        .i_cry   (cry_in),
        .o_vld   (vld_out),
        .i_rdy   (rdy_in),
        .o_res   (res_out),
        .o_cry   (cry_out),
        .o_busy  (busy_out)
    );

    add_nnbit_serial_ctrl #(.DATA_WIDTH(8)) dut8 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_vld   (vld_in8),
        .o_rdy   (rdy_out8),
        .i_num_a (num_a8),
        .i_num_b (num_b8),
        .i_cry   (cry_in8),
        .o_vld   (vld_out8),
        .i_rdy   (rdy_in8),
        .o_res   (res_out8),
        .o_cry   (cry_out8),
        .o_busy  (busy_out8)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete W=4 transaction. hold = cycles of backpressure in DONE;
    // disturb = scramble operands and keep i_vld high while in RUN.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [3:0] er, input logic ec,
                         input int hold, input bit disturb);
        int n;
        n = 0;
        while (!rdy_out && n < 20) begin
            step();
            n++;
        end
        check("op_rdy", 32'(rdy_out), 32'(1));
        vld_in = 1'b1;
        num_a  = a;
        num_b  = b;
        cry_in = c;
        step();
        if (disturb) begin
            num_a  = 4'b0000;
            num_b  = 4'b0000;
            cry_in = 1'b0;
        end else begin
            vld_in = 1'b0;
        end
        check("op_run_flags", 32'({rdy_out, busy_out, vld_out}), 32'(3'b010));
        n = 0;
        while (!vld_out && n < 20) begin
            step();
            n++;
        end
        vld_in = 1'b0;
        check("op_latency", 32'(n), 32'(4));
        check("op_sum", 32'({cry_out, res_out}), 32'({ec, er}));
        for (int i = 0; i < hold; i++) begin
            step();
            check("op_hold", 32'({vld_out, busy_out, cry_out, res_out}), 32'({2'b11, ec, er}));
        end
        rdy_in = 1'b1;
        step();
        rdy_in = 1'b0;
        check("op_idle", 32'({rdy_out, vld_out, busy_out}), 32'(3'b100));
        check("op_keep", 32'({cry_out, res_out}), 32'({ec, er}));
        $display("w4 a=%b b=%b cin=%0d -> res=%b cry=%0d (exp %b %0d)",
                 a, b, c, res_out, cry_out, er, ec);
    endtask

    // One complete W=8 transaction against the reference sum.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n;
        logic [8:0] exp_sum;
        exp_sum = {1'b0, a} + {1'b0, b} + {8'd0, c};
        n = 0;
        while (!rdy_out8 && n < 30) begin
            step();
            n++;
        end
        vld_in8 = 1'b1;
        num_a8  = a;
        num_b8  = b;
        cry_in8 = c;
        step();
        vld_in8 = 1'b0;
        n = 0;
        while (!vld_out8 && n < 30) begin
            step();
            n++;
        end
        check("w8_latency", 32'(n), 32'(8));
        check("w8_sum", 32'({cry_out8, res_out8}), 32'(exp_sum));
        rdy_in8 = 1'b1;
        step();
        rdy_in8 = 1'b0;
        $display("w8 a=%h b=%h cin=%0d -> res=%h cry=%0d (exp %h)",
                 a, b, c, res_out8, cry_out8, exp_sum);
    endtask

    initial begin
        int n;
        int nacc;
        int vld_seen;
        int acc[8];
        logic [3:0] ra, rb;
        logic       rc;
        logic [4:0] rsum;

        rst = 1'b1;
        vld_in = 1'b0; rdy_in = 1'b0; num_a = '0; num_b = '0; cry_in = 1'b0;
        vld_in8 = 1'b0; rdy_in8 = 1'b0; num_a8 = '0; num_b8 = '0; cry_in8 = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state held for 10 idle cycles.
        for (int i = 0; i < 10; i++) begin
            check("reset_idle", 32'({rdy_out, vld_out, busy_out, cry_out, res_out}),
                  32'({3'b100, 5'b00000}));
            step();
        end
        check("reset_idle_w8", 32'({rdy_out8, vld_out8, busy_out8, cry_out8, res_out8}),
              32'({3'b100, 9'd0}));

        // Basic sums.
        do_op(4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 0, 1'b0);
        do_op(4'b1100, 4'b1001, 1'b0, 4'b0101, 1'b1, 0, 1'b0);
        do_op(4'b0101, 4'b0101, 1'b1, 4'b1011, 1'b0, 0, 1'b0);
        do_op(4'b0110, 4'b1100, 1'b1, 4'b0011, 1'b1, 0, 1'b0);

        // Backpressure: 5 cycles of i_rdy=0 in DONE.
        do_op(4'b0111, 4'b0110, 1'b0, 4'b1101, 1'b0, 5, 1'b0);

        // Operand change and i_vld held high during RUN.
        do_op(4'b1110, 4'b1001, 1'b1, 4'b1000, 1'b1, 0, 1'b1);

        // Reset two cycles into RUN.
        vld_in = 1'b1; num_a = 4'b1111; num_b = 4'b0001; cry_in = 1'b0;
        step();
        vld_in = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrun_reset", 32'({rdy_out, vld_out, busy_out, cry_out, res_out}),
              32'({3'b100, 5'b00000}));
        vld_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (vld_out) vld_seen++;
            step();
        end
        check("midrun_no_vld", 32'(vld_seen), 32'(0));
        $display("w4 reset mid-RUN, o_vld pulses seen=%0d", vld_seen);
        do_op(4'b0010, 4'b0110, 1'b1, 4'b1001, 1'b0, 0, 1'b0);

        // Back-to-back with i_vld and i_rdy tied high: 0011+0101 = 0_1000.
        num_a = 4'b0011; num_b = 4'b0101; cry_in = 1'b0;
        vld_in = 1'b1;
        rdy_in = 1'b1;
        nacc = 0;
        for (int k = 0; k < 40; k++) begin
            if (rdy_out && vld_in && nacc < 8) begin
                acc[nacc] = k;
                nacc++;
            end
            if (vld_out) check("b2b_sum", 32'({cry_out, res_out}), 32'(5'b01000));
            step();
        end
        vld_in = 1'b0;
        check("b2b_count", 32'(nacc >= 5), 32'(1));
        for (int i = 1; i < 5; i++) begin
            check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'(6));
        end
        $display("w4 back-to-back accepts=%0d first spacing=%0d", nacc, acc[1] - acc[0]);
        n = 0;
        while (!rdy_out && n < 20) begin
            step();
            n++;
        end
        rdy_in = 1'b0;

        // Random vectors at W=4 against the reference sum.
        for (int i = 0; i < 100; i++) begin
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            rc   = 1'($urandom_range(0, 1));
            rsum = {1'b0, ra} + {1'b0, rb} + {4'd0, rc};
            do_op(ra, rb, rc, rsum[3:0], rsum[4], 0, 1'b0);
        end

        // W=8: boundaries, then 1000 random vectors.
        do_op8(8'hFF, 8'hFF, 1'b1);
        do_op8(8'h00, 8'h00, 1'b0);
        do_op8(8'hFF, 8'h00, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            do_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
